// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage with IF/ID pipeline register.
// One outstanding imem request; a skid entry holds a response that arrives while decode is stalled.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_REQ  | presenting PC to imem (request valid unless StallF)
//   S_WAIT | request accepted, waiting for the response
//   S_HOLD | response parked in skid because decode was stalled
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'hBFC00000,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        StallF,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   output logic        ImemReq,
   output logic [31:0] ImemAddr,
   input  logic        ImemReady,
   input  logic        ImemRValid,
   input  logic [31:0] ImemRData,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD,
   output logic        FetchBusy
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc_f, pc_req, skid_instr, skid_pc;
   logic [31:0] target;
   logic        drop;
   logic        accept, resp_ok, skid_ok, skid_wr;

   assign target    = {PCTargetE[31:2], 2'b00};
   assign ImemAddr  = pc_f;
   // Gated by rst_n so no request escapes while reset is held.
   assign ImemReq   = rst_n & (state == S_REQ) & ~StallF;
   assign accept    = ImemReq & ImemReady;
   assign resp_ok   = (state == S_WAIT) & ImemRValid & ~drop & ~PCSrcE;
   assign skid_ok   = (state == S_HOLD) & ~PCSrcE;
   assign skid_wr   = resp_ok & ~FlushD & StallD;
   assign FetchBusy = (state != S_REQ);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_REQ;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_REQ:  if (accept) state_nxt = S_WAIT;
         S_WAIT: if (ImemRValid) state_nxt = skid_wr ? S_HOLD : S_REQ;
         S_HOLD: if (PCSrcE || !StallD) state_nxt = S_REQ;
         default: state_nxt = S_REQ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_f       <= RESET_PC;
         pc_req     <= RESET_PC;
         drop       <= 1'b0;
         skid_instr <= NOP_INSTR;
         skid_pc    <= '0;
      end else begin
         if (PCSrcE)       pc_f <= target;
         else if (StallF)  pc_f <= pc_f;
         else if (accept)  pc_f <= pc_f + 32'd4;

         if (accept) pc_req <= pc_f;

         // A response in flight when a redirect lands belongs to the old path.
         if ((state == S_WAIT) && ImemRValid)             drop <= 1'b0;
         else if (PCSrcE && ((state == S_WAIT) || accept)) drop <= 1'b1;

         if (skid_wr) begin
            skid_instr <= ImemRData;
            skid_pc    <= pc_req;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         InstrD   <= NOP_INSTR;
         PCD      <= '0;
         PCPlus4D <= '0;
         ValidD   <= 1'b0;
      end else if (FlushD) begin
         InstrD   <= NOP_INSTR;
         PCD      <= '0;
         PCPlus4D <= '0;
         ValidD   <= 1'b0;
      end else if (StallD) begin
         InstrD   <= InstrD;
      end else if (resp_ok) begin
         InstrD   <= ImemRData;
         PCD      <= pc_req;
         PCPlus4D <= pc_req + 32'd4;
         ValidD   <= 1'b1;
      end else if (skid_ok) begin
         InstrD   <= skid_instr;
         PCD      <= skid_pc;
         PCPlus4D <= skid_pc + 32'd4;
         ValidD   <= 1'b1;
      end else begin
         InstrD   <= NOP_INSTR;
         ValidD   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table plus hand-written
// sequences for reset-during-WAIT and PC wraparound.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h00000013;
   localparam logic [31:0] B   = 32'hBFC00000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        StallF, StallD, FlushD, PCSrcE;
   logic [31:0] PCTargetE;
   logic        ImemReq;
   logic [31:0] ImemAddr;
   logic        ImemReady, ImemRValid;
   logic [31:0] ImemRData;
   logic [31:0] InstrD, PCD, PCPlus4D;
   logic        ValidD, FetchBusy;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk(clk), .rst_n(rst_n),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
      .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemReady(ImemReady),
      .ImemRValid(ImemRValid), .ImemRData(ImemRData),
      .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .ValidD(ValidD), .FetchBusy(FetchBusy)
   );

   typedef struct {
      logic        sf, sd, fd, pcs;
      logic [31:0] tgt;
      logic        rdy, rv;
      logic [31:0] rd;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_busy, e_valid;
      logic [31:0] e_instr;
      logic        chk_pc;
      logic [31:0] e_pcd, e_pcp4;
   } vec_t;

   localparam int NV = 23;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic sf, sd, fd, pcs, input logic [31:0] tgt,
                        input logic rdy, rv, input logic [31:0] rd);
      StallF = sf; StallD = sd; FlushD = fd; PCSrcE = pcs; PCTargetE = tgt;
      ImemReady = rdy; ImemRValid = rv; ImemRData = rd;
   endtask

   initial begin
      //            sf sd fd pcs tgt           rdy rv rd            req addr          busy vld instr         chk pcd           pcp4
      vecs[0]  = '{0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        1, B,            0, 0, NOP,          1, 32'h0,        32'h0};
      vecs[1]  = '{0, 0, 0, 0, 32'h0,        1, 1, 32'h00500093, 0, 32'h0,        1, 0, NOP,          1, 32'h0,        32'h0};
      vecs[2]  = '{0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1, B+4,          0, 1, 32'h00500093, 1, B,            B+4};
      vecs[3]  = '{0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        1, B+4,          0, 0, NOP,          0, 32'h0,        32'h0};
      vecs[4]  = '{0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 0, NOP,          0, 32'h0,        32'h0};
      vecs[5]  = '{0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 0, NOP,          0, 32'h0,        32'h0};
      vecs[6]  = '{0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 0, NOP,          0, 32'h0,        32'h0};
      vecs[7]  = '{0, 0, 0, 0, 32'h0,        1, 1, 32'h00A00113, 0, 32'h0,        1, 0, NOP,          0, 32'h0,        32'h0};
      vecs[8]  = '{0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        1, B+8,          0, 1, 32'h00A00113, 1, B+4,          B+8};
      vecs[9]  = '{0, 1, 0, 0, 32'h0,        1, 1, 32'h00100193, 0, 32'h0,        1, 0, NOP,          0, 32'h0,        32'h0};
      vecs[10] = '{0, 1, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 0, NOP,          0, 32'h0,        32'h0};
      vecs[11] = '{0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 0, NOP,          0, 32'h0,        32'h0};
      vecs[12] = '{0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        1, B+12,         0, 1, 32'h00100193, 1, B+8,          B+12};
      vecs[13] = '{0, 0, 0, 1, 32'hBFC00102, 0, 0, 32'h0,        0, 32'h0,        1, 0, NOP,          0, 32'h0,        32'h0};
      vecs[14] = '{0, 0, 0, 0, 32'h0,        0, 1, 32'h12345678, 0, 32'h0,        1, 0, NOP,          0, 32'h0,        32'h0};
      vecs[15] = '{0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hBFC00100, 0, 0, NOP,          0, 32'h0,        32'h0};
      vecs[16] = '{0, 0, 0, 0, 32'h0,        0, 1, 32'h00208233, 0, 32'h0,        1, 0, NOP,          0, 32'h0,        32'h0};
      vecs[17] = '{1, 1, 0, 1, 32'hBFC00200, 1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h00208233, 1, 32'hBFC00100, 32'hBFC00104};
      vecs[18] = '{1, 0, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h00208233, 1, 32'hBFC00100, 32'hBFC00104};
      vecs[19] = '{0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hBFC00200, 0, 0, NOP,          1, 32'h0,        32'h0};
      vecs[20] = '{0, 0, 0, 0, 32'h0,        0, 1, 32'h00000073, 0, 32'h0,        1, 0, NOP,          0, 32'h0,        32'h0};
      vecs[21] = '{0, 1, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hBFC00204, 0, 1, 32'h00000073, 1, 32'hBFC00200, 32'hBFC00204};
      vecs[22] = '{0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h00000073, 1, 32'hBFC00200, 32'hBFC00204};

      rst_n = 1'b0;
      drive(0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
      repeat (2) @(negedge clk);
      chk("rst req",   {31'b0, ImemReq},   32'd0);
      chk("rst instr", InstrD,             NOP);
      chk("rst pcd",   PCD,                32'h0);
      chk("rst pcp4",  PCPlus4D,           32'h0);
      chk("rst valid", {31'b0, ValidD},    32'd0);
      chk("rst busy",  {31'b0, FetchBusy}, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vecs[i].sf, vecs[i].sd, vecs[i].fd, vecs[i].pcs, vecs[i].tgt,
               vecs[i].rdy, vecs[i].rv, vecs[i].rd);
         #1;
         chk($sformatf("v%0d req", i),   {31'b0, ImemReq},   {31'b0, vecs[i].e_req});
         if (vecs[i].e_req)
            chk($sformatf("v%0d addr", i), ImemAddr, vecs[i].e_addr);
         chk($sformatf("v%0d busy", i),  {31'b0, FetchBusy}, {31'b0, vecs[i].e_busy});
         chk($sformatf("v%0d valid", i), {31'b0, ValidD},    {31'b0, vecs[i].e_valid});
         chk($sformatf("v%0d instr", i), InstrD,             vecs[i].e_instr);
         if (vecs[i].chk_pc) begin
            chk($sformatf("v%0d pcd", i),  PCD,      vecs[i].e_pcd);
            chk($sformatf("v%0d pcp4", i), PCPlus4D, vecs[i].e_pcp4);
         end
      end

      // Reset while a request is outstanding and IF/ID holds a valid instruction.
      @(negedge clk);
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 32'h0, 1, 0, 32'h0);
      #1;
      chk("midrst req",   {31'b0, ImemReq},   32'd0);
      chk("midrst instr", InstrD,             NOP);
      chk("midrst pcd",   PCD,                32'h0);
      chk("midrst valid", {31'b0, ValidD},    32'd0);
      chk("midrst busy",  {31'b0, FetchBusy}, 32'd0);

      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 32'h0, 0, 1, 32'hBAD00013);
      #1;
      chk("rel req",  {31'b0, ImemReq}, 32'd1);
      chk("rel addr", ImemAddr,         B);

      @(negedge clk);
      drive(0, 0, 0, 0, 32'h0, 1, 0, 32'h0);
      #1;
      chk("late valid", {31'b0, ValidD},    32'd0);
      chk("late instr", InstrD,             NOP);
      chk("late busy",  {31'b0, FetchBusy}, 32'd0);
      chk("late addr",  ImemAddr,           B);

      @(negedge clk);
      drive(0, 0, 0, 0, 32'h0, 0, 1, 32'h00300213);
      #1;
      chk("restart busy", {31'b0, FetchBusy}, 32'd1);

      // Redirect under StallF to an unaligned target near the top of memory.
      @(negedge clk);
      drive(1, 0, 0, 1, 32'hFFFFFFFF, 1, 0, 32'h0);
      #1;
      chk("restart instr", InstrD,          32'h00300213);
      chk("restart pcd",   PCD,             B);
      chk("restart pcp4",  PCPlus4D,        B+4);
      chk("stallf req",    {31'b0, ImemReq}, 32'd0);

      @(negedge clk);
      drive(0, 0, 0, 0, 32'h0, 1, 0, 32'h0);
      #1;
      chk("wrap req",  {31'b0, ImemReq}, 32'd1);
      chk("wrap addr", ImemAddr,         32'hFFFFFFFC);

      @(negedge clk);
      drive(0, 0, 0, 0, 32'h0, 0, 1, 32'h00400293);

      @(negedge clk);
      drive(0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
      #1;
      chk("wrap instr", InstrD,           32'h00400293);
      chk("wrap pcd",   PCD,              32'hFFFFFFFC);
      chk("wrap pcp4",  PCPlus4D,         32'h0);
      chk("wrap next",  ImemAddr,         32'h0);
      chk("wrap nreq",  {31'b0, ImemReq}, 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage RV32I core.
- Owns the PC register and drives instruction-memory requests over a ready/valid interface, with at most one request outstanding.
- Delivers InstrD/PCD/PCPlus4D to decode.
- Obeys StallF/StallD/FlushD and the PCSrcE/PCTargetE redirect produced by the hazard/execute logic.
- Inserts NOP bubbles when memory is slow.

Parameters:
RESET_PC, 32'hBFC00000, PC value loaded on reset
NOP_INSTR, 32'h00000013, encoding placed in IF/ID on bubble/flush (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
StallF  in  1  freeze PC / inhibit new request
StallD  in  1  hold IF/ID contents
FlushD  in  1  clear IF/ID to bubble
PCSrcE  in  1  taken branch/jump resolved in execute
PCTargetE  in  32  redirect target
ImemReq  out  1  request valid
ImemAddr  out  32  request address (word aligned)
ImemReady  in  1  memory accepts request this cycle
ImemRValid  in  1  response valid (earliest one cycle after acceptance)
ImemRData  in  32  response instruction
InstrD  out  32  IF/ID instruction
PCD  out  32  IF/ID PC
PCPlus4D  out  32  IF/ID PC+4
ValidD  out  1  IF/ID holds a real instruction
FetchBusy  out  1  request outstanding or skid occupied (status only)

Behaviour:
- Reset (async, rst_n=0):
  - PCF=RESET_PC, state=REQ, Drop=0, skid empty.
  - InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, ImemReq=0 while in reset.
- States:
  - REQ: ImemReq = ~StallF; ImemAddr=PCF (combinational from PCF, may change while unaccepted).
  - WAIT: request accepted, awaiting response; ImemReq=0.
  - HOLD: response captured in skid (instr+PC) because StallD=1; ImemReq=0.
- Transitions:
  - REQ & ImemReq & ImemReady -> WAIT. Latch PCReq=PCF; PCF<=PCF+4.
  - WAIT & ImemRValid:
    - Drop=1 -> discard response, Drop<=0, go to REQ.
    - Otherwise StallD=0 -> load IF/ID, go to REQ.
    - Otherwise StallD=1 -> write skid, go to HOLD.
  - HOLD & StallD=0 -> load IF/ID from skid, go to REQ.
  - ImemRValid outside WAIT is a protocol error; it is ignored.
- Redirect (PCSrcE=1), takes priority over StallF:
  - PCF<=PCTargetE.
  - In WAIT without ImemRValid, or in REQ with acceptance in the same cycle: Drop<=1.
  - In WAIT with ImemRValid in the same cycle: the response is discarded.
  - In HOLD: skid invalidated, go to REQ.
  - The redirect target is requested no earlier than the following cycle.
- PC update priority: PCSrcE > StallF (hold) > acceptance (+4) > hold.
- IF/ID update priority each cycle:
  1. FlushD: InstrD=NOP_INSTR, ValidD=0, PCD/PCPlus4D=0.
  2. StallD: hold all.
  3. Deliverable instruction (response or skid): InstrD, PCD=PC, PCPlus4D=PC+4, ValidD=1.
  4. Otherwise bubble: InstrD=NOP_INSTR, ValidD=0.
- Same-cycle FlushD and deliverable response: the response is consumed and discarded, never placed in the skid.
- Arithmetic: PC+4 wraps modulo 2^32; bits [1:0] of PCTargetE are forced to 0.
- FetchBusy = (state!=REQ).
- Zero-wait memory (ImemReady=1, RValid the cycle after acceptance) sustains one instruction every 2 cycles. Throughput beyond that is out of scope.

Test Plan:
- Reset release, ImemReady=1, 1-cycle latency, RData=0x00500093 -> first ImemAddr=0xBFC00000; InstrD=0x00500093, PCD=0xBFC00000, PCPlus4D=0xBFC00004, ValidD=1 two cycles after acceptance; next ImemAddr=0xBFC00004.
- Response delayed 3 cycles -> InstrD=NOP_INSTR, ValidD=0 on each waiting cycle; FetchBusy=1 throughout; then the valid instruction loads.
- StallD=1 during response arrival for 2 cycles -> IF/ID unchanged, state HOLD, no ImemReq; StallD falls -> skid instruction appears in IF/ID the next cycle.
- PCSrcE=1, PCTargetE=0xBFC00100 while in WAIT -> stale response dropped (ValidD stays 0); next ImemAddr=0xBFC00100; PCD=0xBFC00100 on delivery.
- StallF=1 & StallD=1 with PCSrcE=1 in the same cycle -> PCF becomes target; FlushD=1 forces InstrD=NOP_INSTR, ValidD=0.
- rst_n asserted mid-WAIT -> outputs return to reset values immediately; the late ImemRValid after release is ignored; fetch restarts at RESET_PC.
